// File: rtl/ppi_bus_ctrl_pkg.sv
// Shared definitions for the 8255A PPI bus-side control stage:
// register address codes, reset control word, FSM encoding and
// control word bit positions.
package ppi_bus_ctrl_pkg;

    // CPU register address codes on A[1:0]
    localparam logic [1:0] PPI_A_PA = 2'b00;
    localparam logic [1:0] PPI_A_PB = 2'b01;
    localparam logic [1:0] PPI_A_PC = 2'b10;
    localparam logic [1:0] PPI_A_CW = 2'b11;

    // Mode 0, all ports input
    localparam logic [7:0] CW_RESET_DEFAULT = 8'h9B;

    // Control word bit positions
    localparam int CW_MODE_FLAG = 7;
    localparam int BSR_BIT_MSB  = 3;
    localparam int BSR_BIT_LSB  = 1;
    localparam int BSR_VAL      = 0;

    // Bus cycle FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_READ   = 2'd3
    } state_t;

    // Read-back multiplexer; the control register is not readable.
    function automatic logic [7:0] f_rd_mux(input logic [1:0] a,
                                            input logic [7:0] pa,
                                            input logic [7:0] pb,
                                            input logic [7:0] pc);
        logic [7:0] v;
        case (a)
            PPI_A_PA: v = pa;
            PPI_A_PB: v = pb;
            PPI_A_PC: v = pc;
            default:  v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ppi_sync.sv
// Multi-flop synchroniser for an active-low asynchronous CPU strobe.
// Resets to 1 so the strobe reads as inactive while Reset is held.
module ppi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic Reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous pin through the flop chain
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ppi_bus_ctrl.sv
// Bus-side control stage of the 8255A PPI. Synchronises the CPU strobes,
// owns the control word register, turns each completed write into a
// one-clock strobe and drives the registered read-back path.
// SYNC_STAGES must be in 2..4.
module ppi_bus_ctrl
    import ppi_bus_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CW_RESET    = CW_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       nCs,
    input  logic       nRd,
    input  logic       nWr,
    input  logic [1:0] A,
    input  logic [7:0] d_in,
    input  logic [7:0] rd_pa,
    input  logic [7:0] rd_pb,
    input  logic [7:0] rd_pc,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic [7:0] controlword,
    output logic [7:0] wr_data,
    output logic       pa_wr_stb,
    output logic       pb_wr_stb,
    output logic       pc_wr_stb,
    output logic       mode_set_stb,
    output logic       pc_bsr_stb,
    output logic [2:0] pc_bsr_bit,
    output logic       pc_bsr_val
);

    logic       w_s_cs;
    logic       w_s_rd;
    logic       w_s_wr;
    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_commit;
    logic       w_latch;
    logic       w_rd_active;

    logic [1:0] r_a_q;
    logic [7:0] r_wr_data;
    logic [7:0] r_cw;
    logic       r_pa_stb;
    logic       r_pb_stb;
    logic       r_pc_stb;
    logic       r_mode_stb;
    logic       r_bsr_stb;
    logic [2:0] r_bsr_bit;
    logic       r_bsr_val;
    logic [7:0] r_d_out;
    logic       r_d_oe;

    ppi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .Reset(Reset), .i_async(nCs), .o_sync(w_s_cs)
    );
    ppi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk(clk), .Reset(Reset), .i_async(nRd), .o_sync(w_s_rd)
    );
    ppi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk(clk), .Reset(Reset), .i_async(nWr), .o_sync(w_s_wr)
    );

    // Bus cycle state register
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; write wins over a simultaneous read, control reads are ignored
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_s_cs && !w_s_wr) begin
                    w_state_nxt = ST_WRITE;
                end else if (!w_s_cs && !w_s_rd && (A != PPI_A_CW)) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                if (w_s_wr || w_s_cs) begin
                    w_state_nxt = ST_COMMIT;
                    w_commit    = 1'b1;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            ST_READ: begin
                if (w_s_rd || w_s_cs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sampling on the IDLE->WRITE edge too keeps a one-cycle write from using stale data
    assign w_latch     = (w_state_nxt == ST_WRITE);
    assign w_rd_active = (w_state_nxt == ST_READ);

    // Write capture and trailing-edge decode into one-clock strobes
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_a_q      <= PPI_A_PA;
            r_wr_data  <= 8'h00;
            r_cw       <= CW_RESET;
            r_pa_stb   <= 1'b0;
            r_pb_stb   <= 1'b0;
            r_pc_stb   <= 1'b0;
            r_mode_stb <= 1'b0;
            r_bsr_stb  <= 1'b0;
            r_bsr_bit  <= 3'd0;
            r_bsr_val  <= 1'b0;
        end else begin
            r_pa_stb   <= 1'b0;
            r_pb_stb   <= 1'b0;
            r_pc_stb   <= 1'b0;
            r_mode_stb <= 1'b0;
            r_bsr_stb  <= 1'b0;
            if (w_latch) begin
                r_a_q     <= A;
                r_wr_data <= d_in;
            end
            if (w_commit) begin
                case (r_a_q)
                    PPI_A_PA: r_pa_stb <= 1'b1;
                    PPI_A_PB: r_pb_stb <= 1'b1;
                    PPI_A_PC: r_pc_stb <= 1'b1;
                    default: begin
                        if (r_wr_data[CW_MODE_FLAG]) begin
                            r_cw       <= r_wr_data;
                            r_mode_stb <= 1'b1;
                        end else begin
                            r_bsr_stb <= 1'b1;
                            r_bsr_bit <= r_wr_data[BSR_BIT_MSB:BSR_BIT_LSB];
                            r_bsr_val <= r_wr_data[BSR_VAL];
                        end
                    end
                endcase
            end
        end
    end

    // Read-back path follows live port data while a read is in progress
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_d_oe  <= 1'b0;
            r_d_out <= 8'h00;
        end else begin
            r_d_oe  <= w_rd_active;
            r_d_out <= w_rd_active ? f_rd_mux(A, rd_pa, rd_pb, rd_pc) : 8'h00;
        end
    end

    assign d_out        = r_d_out;
    assign d_oe         = r_d_oe;
    assign controlword  = r_cw;
    assign wr_data      = r_wr_data;
    assign pa_wr_stb    = r_pa_stb;
    assign pb_wr_stb    = r_pb_stb;
    assign pc_wr_stb    = r_pc_stb;
    assign mode_set_stb = r_mode_stb;
    assign pc_bsr_stb   = r_bsr_stb;
    assign pc_bsr_bit   = r_bsr_bit;
    assign pc_bsr_val   = r_bsr_val;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Testbench for ppi_bus_ctrl: directed scenarios plus randomized CPU
// cycles checked against a transaction-level model of the PPI bus rules.
module tb_ppi_bus_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       nCs = 1'b1;
    logic       nRd = 1'b1;
    logic       nWr = 1'b1;
    logic [1:0] A = 2'b00;
    logic [7:0] d_in = 8'h00;
    logic [7:0] rd_pa = 8'h00;
    logic [7:0] rd_pb = 8'h00;
    logic [7:0] rd_pc = 8'h00;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] controlword;
    logic [7:0] wr_data;
    logic       pa_wr_stb, pb_wr_stb, pc_wr_stb, mode_set_stb, pc_bsr_stb;
    logic [2:0] pc_bsr_bit;
    logic       pc_bsr_val;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_cw = 8'h9B;
    logic [7:0] m_wr = 8'h00;
    logic [2:0] m_bsr_bit = 3'd0;
    logic       m_bsr_val = 1'b0;

    wire [4:0] w_stb = {pa_wr_stb, pb_wr_stb, pc_wr_stb, mode_set_stb, pc_bsr_stb};

    ppi_bus_ctrl #(.SYNC_STAGES(N), .CW_RESET(8'h9B)) dut (
        .clk(clk), .Reset(Reset), .nCs(nCs), .nRd(nRd), .nWr(nWr), .A(A),
        .d_in(d_in), .rd_pa(rd_pa), .rd_pb(rd_pb), .rd_pc(rd_pc),
        .d_out(d_out), .d_oe(d_oe), .controlword(controlword), .wr_data(wr_data),
        .pa_wr_stb(pa_wr_stb), .pb_wr_stb(pb_wr_stb), .pc_wr_stb(pc_wr_stb),
        .mode_set_stb(mode_set_stb), .pc_bsr_stb(pc_bsr_stb),
        .pc_bsr_bit(pc_bsr_bit), .pc_bsr_val(pc_bsr_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Which strobe a committed write to address a with data d must produce
    function automatic logic [4:0] exp_stb(input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'd0:    return 5'b10000;
            2'd1:    return 5'b01000;
            2'd2:    return 5'b00100;
            default: return d[7] ? 5'b00010 : 5'b00001;
        endcase
    endfunction

    function automatic logic [7:0] port_val(input logic [1:0] a);
        case (a)
            2'd0:    return rd_pa;
            2'd1:    return rd_pb;
            2'd2:    return rd_pc;
            default: return 8'h00;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if (w_stb !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_stb: got %b expected 00000", w_stb);
            end
        end
    endtask

    // One CPU write cycle: nWr low for len clocks, then released
    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic cs, input int len);
        logic [4:0] req;
        logic [4:0] e;
        A = a; d_in = d; nCs = cs; nWr = 1'b0;
        for (int i = 0; i < len; i++) begin
            tick();
            n_checks++;
            if (w_stb !== 5'b0) begin
                n_fail++;
                $display("FAIL wr_low_stb: got %b expected 00000", w_stb);
            end
        end
        nWr = 1'b1;
        req = cs ? 5'b0 : exp_stb(a, d);
        if (!cs) begin
            m_wr = d;
            if (a == 2'd3) begin
                if (d[7]) m_cw = d;
                else begin
                    m_bsr_bit = d[3:1];
                    m_bsr_val = d[0];
                end
            end
        end
        for (int i = 1; i <= N + 3; i++) begin
            tick();
            e = (i == N + 1) ? req : 5'b0;
            n_checks++;
            if (w_stb !== e) begin
                n_fail++;
                $display("FAIL wr_stb a=%0d d=%h cs=%0d t=%0d: got %b expected %b", a, d, cs, i, w_stb, e);
            end
            n_checks++;
            if (d_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_d_oe: got %b expected 0", d_oe);
            end
            if (i >= N + 1) begin
                n_checks++;
                if (controlword !== m_cw) begin
                    n_fail++;
                    $display("FAIL wr_cw t=%0d: got %h expected %h", i, controlword, m_cw);
                end
                n_checks++;
                if (wr_data !== m_wr) begin
                    n_fail++;
                    $display("FAIL wr_data: got %h expected %h", wr_data, m_wr);
                end
                n_checks++;
                if ({pc_bsr_bit, pc_bsr_val} !== {m_bsr_bit, m_bsr_val}) begin
                    n_fail++;
                    $display("FAIL wr_bsr: got %h/%b expected %h/%b", pc_bsr_bit, pc_bsr_val, m_bsr_bit, m_bsr_val);
                end
            end
        end
        nCs = 1'b1;
        idle(N + 1);
    endtask

    // One CPU read cycle; port values are inverted each hold clock to check tracking
    task automatic do_read(input logic [1:0] a, input logic [7:0] pa, input logic [7:0] pb,
                           input logic [7:0] pc, input int hold);
        logic       eoe;
        logic [7:0] eout;
        rd_pa = pa; rd_pb = pb; rd_pc = pc;
        A = a; nCs = 1'b0; nRd = 1'b0;
        for (int i = 1; i <= N + 1; i++) begin
            tick();
            eoe  = (a != 2'd3) && (i == N + 1);
            eout = eoe ? port_val(a) : 8'h00;
            n_checks++;
            if ({d_oe, d_out} !== {eoe, eout}) begin
                n_fail++;
                $display("FAIL rd_start a=%0d t=%0d: got %b/%h expected %b/%h", a, i, d_oe, d_out, eoe, eout);
            end
        end
        for (int k = 0; k < hold; k++) begin
            rd_pa = ~rd_pa; rd_pb = ~rd_pb; rd_pc = ~rd_pc;
            tick();
            eoe  = (a != 2'd3);
            eout = eoe ? port_val(a) : 8'h00;
            n_checks++;
            if ({d_oe, d_out} !== {eoe, eout}) begin
                n_fail++;
                $display("FAIL rd_track a=%0d: got %b/%h expected %b/%h", a, d_oe, d_out, eoe, eout);
            end
            n_checks++;
            if (w_stb !== 5'b0) begin
                n_fail++;
                $display("FAIL rd_stb: got %b expected 00000", w_stb);
            end
        end
        nRd = 1'b1;
        for (int i = 1; i <= N + 1; i++) begin
            tick();
            eoe  = (a != 2'd3) && (i <= N);
            eout = eoe ? port_val(a) : 8'h00;
            n_checks++;
            if ({d_oe, d_out} !== {eoe, eout}) begin
                n_fail++;
                $display("FAIL rd_end a=%0d t=%0d: got %b/%h expected %b/%h", a, i, d_oe, d_out, eoe, eout);
            end
        end
        nCs = 1'b1;
        idle(N + 1);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (controlword !== 8'h9B) begin
            n_fail++;
            $display("FAIL reset_cw: got %h expected 9b", controlword);
        end
        n_checks++;
        if ({d_oe, d_out, wr_data} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %b/%h/%h expected 0/00/00", d_oe, d_out, wr_data);
        end
        n_checks++;
        if ({w_stb, pc_bsr_bit, pc_bsr_val} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_stb: got %b/%h/%b expected zeros", w_stb, pc_bsr_bit, pc_bsr_val);
        end
        Reset = 1'b0;
        m_cw = 8'h9B; m_wr = 8'h00; m_bsr_bit = 3'd0; m_bsr_val = 1'b0;
        idle(2);
    endtask

    task automatic test_mode_set();
        do_write(2'd3, 8'h80, 1'b0, 4);
    endtask

    task automatic test_bsr();
        do_write(2'd3, 8'h07, 1'b0, 3);
    endtask

    task automatic test_port_write();
        do_write(2'd0, 8'h5A, 1'b0, 3);
        do_write(2'd1, 8'h11, 1'b0, 2);
        do_write(2'd2, 8'hE4, 1'b0, 2);
        do_write(2'd0, 8'hA6, 1'b1, 3);
    endtask

    task automatic test_read();
        do_read(2'd1, 8'h00, 8'hC3, 8'h00, 1);
        do_read(2'd3, 8'h12, 8'h34, 8'h56, 2);
    endtask

    task automatic test_reset_mid_write();
        n_checks++;
        if (controlword !== 8'h80) begin
            n_fail++;
            $display("FAIL pre_reset_cw: got %h expected 80", controlword);
        end
        A = 2'd3; d_in = 8'h83; nCs = 1'b0; nWr = 1'b0;
        idle(4);
        Reset = 1'b1;
        idle(1);
        nWr = 1'b1; nCs = 1'b1;
        idle(1);
        Reset = 1'b0;
        m_cw = 8'h9B; m_wr = 8'h00; m_bsr_bit = 3'd0; m_bsr_val = 1'b0;
        idle(N + 4);
        n_checks++;
        if (controlword !== 8'h9B) begin
            n_fail++;
            $display("FAIL reset_mid_cw: got %h expected 9b", controlword);
        end
        n_checks++;
        if ({d_oe, wr_data} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_mid_data: got %b/%h expected 0/00", d_oe, wr_data);
        end
    endtask

    task automatic test_rd_wr_together();
        logic [4:0] e;
        A = 2'd0; d_in = 8'hA5; nCs = 1'b0; nRd = 1'b0; nWr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (d_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL rdwr_d_oe: got %b expected 0", d_oe);
            end
        end
        nRd = 1'b1; nWr = 1'b1;
        m_wr = 8'hA5;
        for (int i = 1; i <= N + 3; i++) begin
            tick();
            e = (i == N + 1) ? 5'b10000 : 5'b00000;
            n_checks++;
            if ({w_stb, d_oe} !== {e, 1'b0}) begin
                n_fail++;
                $display("FAIL rdwr_stb t=%0d: got %b/%b expected %b/0", i, w_stb, d_oe, e);
            end
        end
        n_checks++;
        if (wr_data !== m_wr) begin
            n_fail++;
            $display("FAIL rdwr_data: got %h expected %h", wr_data, m_wr);
        end
        nCs = 1'b1;
        idle(N + 1);
    endtask

    task automatic test_random();
        int         kind;
        logic [1:0] a;
        logic [7:0] d;
        logic       cs;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            a    = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            cs   = ($urandom_range(0, 7) == 0);
            if (kind < 2) begin
                do_write(a, d, cs, $urandom_range(2, 5));
            end else begin
                do_read(a, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_set();
        test_bsr();
        test_port_write();
        test_read();
        test_reset_mid_write();
        test_rd_wr_together();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
